// File: rtl/exe_pkg.sv
// exe_pkg: shared types and helpers for the pipeline_exe_mc EXE stage.
//   op_e        - encoded ALU/branch/mul/div operation carried on alu_op_d_i
//   md_state_e  - multi-cycle unit sequencer state
//   is_multicycle / is_branch / is_mul - op class helpers
package exe_pkg;

  localparam int OP_BITS = 5;

  typedef enum logic [OP_BITS-1:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_BEQ    = 5'd10,
    OP_BNE    = 5'd11,
    OP_BLT    = 5'd12,
    OP_BGE    = 5'd13,
    OP_BLTU   = 5'd14,
    OP_BGEU   = 5'd15,
    OP_JALR   = 5'd16,
    OP_MUL    = 5'd17,
    OP_MULH   = 5'd18,
    OP_MULHSU = 5'd19,
    OP_MULHU  = 5'd20,
    OP_DIV    = 5'd21,
    OP_DIVU   = 5'd22,
    OP_REM    = 5'd23,
    OP_REMU   = 5'd24
  } op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  function automatic logic is_mul(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic is_multicycle(input op_e op);
    return is_mul(op) | (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
  endfunction

  // Conditional branches only; JALR is resolved separately.
  function automatic logic is_branch(input op_e op);
    return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
  endfunction

endpackage

// File: rtl/exe_muldiv.sv
// exe_muldiv: multi-cycle unit for MUL*/DIV*/REM* ops.
//   start_i  - launch op_i on a_i/b_i (only honoured in IDLE)
//   abort_i  - drop any op in flight, back to IDLE
//   ack_i    - result taken, DONE returns to IDLE
//   busy_o   - MUL or DIV state; done_o - DONE state; idle_o - IDLE state
//   result_o - held result, valid while done_o
// The product is formed at launch and held while a counter models the
// MUL_LAT-deep multiplier; division is a restoring radix-2 loop, one bit
// per cycle, on operand magnitudes with signs fixed on the last step.
module exe_muldiv
  import exe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic            ack_i,
  input  op_e             op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            idle_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MUL_LD  = (MUL_LAT > 1) ? CNT_W'(MUL_LAT - 2) : CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_DIV_LD  = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN     = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, result_q, result_d;
  logic             quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d, is_rem_q, is_rem_d;

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   mul_res_s, a_mag_s, b_mag_s, special_s;
  logic [XLEN-1:0]   rem_new_s, quo_new_s, div_res_s;
  logic [XLEN:0]     rem_sh_s, trial_s;
  logic              div_signed_s, is_rem_s, a_neg_s, b_neg_s, div_special_s;

  // Product and divide operand preparation from the launching op
  always_comb begin
    prod_s = {{XLEN{(op_i == OP_MULH || op_i == OP_MULHSU) & a_i[XLEN-1]}}, a_i} *
             {{XLEN{(op_i == OP_MULH) & b_i[XLEN-1]}}, b_i};
    mul_res_s    = (op_i == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    div_signed_s = (op_i == OP_DIV) | (op_i == OP_REM);
    is_rem_s     = (op_i == OP_REM) | (op_i == OP_REMU);
    a_neg_s      = div_signed_s & a_i[XLEN-1];
    b_neg_s      = div_signed_s & b_i[XLEN-1];
    a_mag_s      = a_neg_s ? -a_i : a_i;
    b_mag_s      = b_neg_s ? -b_i : b_i;
    div_special_s = (b_i == '0) | (div_signed_s & (a_i == INT_MIN) & (b_i == '1));
    // x/0: quotient all-ones, remainder x; INT_MIN/-1: quotient INT_MIN, remainder 0
    if (b_i == '0) begin
      special_s = is_rem_s ? a_i : '1;
    end else begin
      special_s = is_rem_s ? '0 : a_i;
    end
  end

  // One restoring-divide step plus sign fix-up of the would-be final values
  always_comb begin
    rem_sh_s = {rem_q, quo_q[XLEN-1]};
    trial_s  = rem_sh_s - {1'b0, dvs_q};
    if (trial_s[XLEN]) begin
      rem_new_s = rem_sh_s[XLEN-1:0];
      quo_new_s = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      rem_new_s = trial_s[XLEN-1:0];
      quo_new_s = {quo_q[XLEN-2:0], 1'b1};
    end
    if (is_rem_q) begin
      div_res_s = rem_neg_q ? -rem_new_s : rem_new_s;
    end else begin
      div_res_s = quo_neg_q ? -quo_new_s : quo_new_s;
    end
  end

  // Sequencer next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: begin
        if (start_i && !abort_i) begin
          if (is_mul(op_i)) begin
            state_d = (MUL_LAT == 1) ? MD_DONE : MD_MUL;
          end else begin
            state_d = div_special_s ? MD_DONE : MD_DIV;
          end
        end else begin
          state_d = MD_IDLE;
        end
      end
      MD_MUL, MD_DIV: begin
        if (abort_i) begin
          state_d = MD_IDLE;
        end else if (cnt_q == '0) begin
          state_d = MD_DONE;
        end else begin
          state_d = state_q;
        end
      end
      MD_DONE: begin
        if (abort_i || ack_i) begin
          state_d = MD_IDLE;
        end else begin
          state_d = MD_DONE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // Counter and datapath register next values
  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    is_rem_d  = is_rem_q;
    case (state_q)
      MD_IDLE: begin
        if (start_i && is_mul(op_i)) begin
          result_d = mul_res_s;
          cnt_d    = CNT_MUL_LD;
        end else if (start_i) begin
          result_d  = special_s;
          cnt_d     = CNT_DIV_LD;
          rem_d     = '0;
          quo_d     = a_mag_s;
          dvs_d     = b_mag_s;
          quo_neg_d = a_neg_s ^ b_neg_s;
          rem_neg_d = a_neg_s;
          is_rem_d  = is_rem_s;
        end else begin
          cnt_d = cnt_q;
        end
      end
      MD_MUL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      MD_DIV: begin
        rem_d = rem_new_s;
        quo_d = quo_new_s;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          result_d = div_res_s;
        end
      end
      MD_DONE: cnt_d = cnt_q;
      default: cnt_d = '0;
    endcase
  end

  // Sequencer and datapath registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      is_rem_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      is_rem_q  <= is_rem_d;
    end
  end

  // State decode outputs
  always_comb begin
    idle_o   = (state_q == MD_IDLE);
    busy_o   = (state_q == MD_MUL) | (state_q == MD_DIV);
    done_o   = (state_q == MD_DONE);
    result_o = result_q;
  end

endmodule

// File: rtl/pipeline_exe_mc.sv
// pipeline_exe_mc: RV32IM EXE stage with multi-cycle MUL/DIV.
//   Inputs : ID operands/op/sideband (*_d_i), flush_e_i, st_e_i.
//   Outputs: stall_e_o to the hazard unit, redirect pulse + pc to IF,
//            EXE/MEM register (*_e_o) with valid bit, forwarding bypass.
// Single-cycle ops retire in one cycle; mul/div hold ID via stall_e_o and
// retire from the DONE state while ID still presents the op.
module pipeline_exe_mc
  import exe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 3,
  parameter int OP_W    = 5
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            valid_d_i,
  input  logic [OP_W-1:0] alu_op_d_i,
  input  logic [XLEN-1:0] rs1_d_i,
  input  logic [XLEN-1:0] rs2_d_i,
  input  logic [XLEN-1:0] extended_imm_d_i,
  input  logic [XLEN-1:0] pc_plus4_d_i,
  input  logic [XLEN-1:0] branch_target_d_i,
  input  logic            taken_d_i,
  input  logic [XLEN-1:0] prediction_pc_d_i,
  input  logic            reg_write_en_d_i,
  input  logic [4:0]      rd_idx_d_i,
  input  logic [3:0]      dmem_type_d_i,
  input  logic [3:0]      result_src_d_i,
  input  logic            flush_e_i,
  input  logic            st_e_i,
  output logic            stall_e_o,
  output logic            redirection_e_o,
  output logic [XLEN-1:0] redirection_pc_e_o,
  output logic            valid_e_o,
  output logic [XLEN-1:0] alu_result_e_o,
  output logic [XLEN-1:0] extended_imm_e_o,
  output logic [XLEN-1:0] pc_plus4_e_o,
  output logic            reg_write_en_e_o,
  output logic [4:0]      rd_idx_e_o,
  output logic [3:0]      dmem_type_e_o,
  output logic [3:0]      result_src_e_o,
  output logic [XLEN-1:0] bypass_e_o,
  output logic            bypass_valid_e_o
);

  localparam int SH_W = $clog2(XLEN);

  op_e             op_s;
  logic            mc_op_s, md_idle_s, md_busy_s, md_done_s, md_start_s, consume_s;
  logic            eq_s, lt_s, ltu_s, br_actual_s;
  logic [SH_W-1:0] shamt_s;
  logic [XLEN-1:0] alu_s, md_result_s, ex_result_s, link_sum_s, jalr_target_s;

  logic            valid_q, valid_d, reg_write_en_q, reg_write_en_d;
  logic [XLEN-1:0] alu_result_q, alu_result_d, ext_imm_q, ext_imm_d, pc_plus4_q, pc_plus4_d;
  logic [4:0]      rd_idx_q, rd_idx_d;
  logic [3:0]      dmem_type_q, dmem_type_d, result_src_q, result_src_d;

  exe_muldiv #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) u_muldiv (
    .clk      (clk),
    .resetn   (resetn),
    .start_i  (md_start_s),
    .abort_i  (flush_e_i),
    .ack_i    (consume_s),
    .op_i     (op_s),
    .a_i      (rs1_d_i),
    .b_i      (rs2_d_i),
    .busy_o   (md_busy_s),
    .done_o   (md_done_s),
    .idle_o   (md_idle_s),
    .result_o (md_result_s)
  );

  // Op decode, handshake with the multi-cycle unit, hazard stall
  always_comb begin
    op_s       = op_e'(alu_op_d_i[OP_BITS-1:0]);
    mc_op_s    = is_multicycle(op_s);
    md_start_s = md_idle_s & valid_d_i & mc_op_s & ~flush_e_i;
    consume_s  = (valid_d_i & ~st_e_i & ~flush_e_i & md_idle_s & ~mc_op_s) |
                 (md_done_s & ~st_e_i & ~flush_e_i);
    stall_e_o  = (md_idle_s & valid_d_i & mc_op_s) | md_busy_s;
  end

  // Compare flags, actual branch outcome and jalr target
  always_comb begin
    shamt_s       = rs2_d_i[SH_W-1:0];
    eq_s          = (rs1_d_i == rs2_d_i);
    lt_s          = ($signed(rs1_d_i) < $signed(rs2_d_i));
    ltu_s         = (rs1_d_i < rs2_d_i);
    link_sum_s    = rs1_d_i + extended_imm_d_i;
    jalr_target_s = {link_sum_s[XLEN-1:1], 1'b0};
    case (op_s)
      OP_BEQ:  br_actual_s = eq_s;
      OP_BNE:  br_actual_s = ~eq_s;
      OP_BLT:  br_actual_s = lt_s;
      OP_BGE:  br_actual_s = ~lt_s;
      OP_BLTU: br_actual_s = ltu_s;
      OP_BGEU: br_actual_s = ~ltu_s;
      default: br_actual_s = 1'b0;
    endcase
  end

  // Single-cycle ALU; branches report their outcome, jalr its link address
  always_comb begin
    case (op_s)
      OP_ADD:  alu_s = rs1_d_i + rs2_d_i;
      OP_SUB:  alu_s = rs1_d_i - rs2_d_i;
      OP_SLL:  alu_s = rs1_d_i << shamt_s;
      OP_SLT:  alu_s = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: alu_s = {{(XLEN-1){1'b0}}, ltu_s};
      OP_XOR:  alu_s = rs1_d_i ^ rs2_d_i;
      OP_SRL:  alu_s = rs1_d_i >> shamt_s;
      OP_SRA:  alu_s = $unsigned($signed(rs1_d_i) >>> shamt_s);
      OP_OR:   alu_s = rs1_d_i | rs2_d_i;
      OP_AND:  alu_s = rs1_d_i & rs2_d_i;
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU:
               alu_s = {{(XLEN-1){1'b0}}, br_actual_s};
      OP_JALR: alu_s = pc_plus4_d_i;
      default: alu_s = '0;
    endcase
  end

  // Forwarding path: in DONE the held mul/div result replaces the ALU
  always_comb begin
    ex_result_s      = md_done_s ? md_result_s : alu_s;
    bypass_e_o       = ex_result_s;
    bypass_valid_e_o = valid_d_i & ((md_idle_s & ~mc_op_s) | md_done_s);
  end

  // Redirect pulse, only on the cycle the branch/jalr actually retires
  always_comb begin
    redirection_e_o    = 1'b0;
    redirection_pc_e_o = '0;
    if (resetn && consume_s && is_branch(op_s)) begin
      if (taken_d_i && !br_actual_s) begin
        redirection_e_o    = 1'b1;
        redirection_pc_e_o = pc_plus4_d_i;
      end else if (!taken_d_i && br_actual_s) begin
        redirection_e_o    = 1'b1;
        redirection_pc_e_o = branch_target_d_i;
      end else begin
        redirection_e_o = 1'b0;
      end
    end else if (resetn && consume_s && op_s == OP_JALR) begin
      redirection_e_o    = ~taken_d_i | (prediction_pc_d_i != jalr_target_s);
      redirection_pc_e_o = jalr_target_s;
    end else begin
      redirection_e_o = 1'b0;
    end
  end

  // EXE/MEM register next values: flush beats stall beats consume
  always_comb begin
    valid_d        = valid_q;
    alu_result_d   = alu_result_q;
    ext_imm_d      = ext_imm_q;
    pc_plus4_d     = pc_plus4_q;
    reg_write_en_d = reg_write_en_q;
    rd_idx_d       = rd_idx_q;
    dmem_type_d    = dmem_type_q;
    result_src_d   = result_src_q;
    if (flush_e_i) begin
      valid_d        = 1'b0;
      reg_write_en_d = 1'b0;
      dmem_type_d    = 4'd0;
    end else if (st_e_i) begin
      valid_d = valid_q;
    end else if (consume_s) begin
      valid_d        = 1'b1;
      alu_result_d   = ex_result_s;
      ext_imm_d      = extended_imm_d_i;
      pc_plus4_d     = pc_plus4_d_i;
      reg_write_en_d = reg_write_en_d_i;
      rd_idx_d       = rd_idx_d_i;
      dmem_type_d    = dmem_type_d_i;
      result_src_d   = result_src_d_i;
    end else begin
      valid_d = 1'b0;
    end
  end

  // EXE/MEM register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q        <= 1'b0;
      alu_result_q   <= '0;
      ext_imm_q      <= '0;
      pc_plus4_q     <= '0;
      reg_write_en_q <= 1'b0;
      rd_idx_q       <= 5'd0;
      dmem_type_q    <= 4'd0;
      result_src_q   <= 4'd0;
    end else begin
      valid_q        <= valid_d;
      alu_result_q   <= alu_result_d;
      ext_imm_q      <= ext_imm_d;
      pc_plus4_q     <= pc_plus4_d;
      reg_write_en_q <= reg_write_en_d;
      rd_idx_q       <= rd_idx_d;
      dmem_type_q    <= dmem_type_d;
      result_src_q   <= result_src_d;
    end
  end

  assign valid_e_o        = valid_q;
  assign alu_result_e_o   = alu_result_q;
  assign extended_imm_e_o = ext_imm_q;
  assign pc_plus4_e_o     = pc_plus4_q;
  assign reg_write_en_e_o = reg_write_en_q;
  assign rd_idx_e_o       = rd_idx_q;
  assign dmem_type_e_o    = dmem_type_q;
  assign result_src_e_o   = result_src_q;

endmodule

// File: tb/tb_pipeline_exe_mc.sv
// Directed bench for pipeline_exe_mc (XLEN=32, MUL_LAT=3).
// Inputs change 1 time unit after a rising edge; combinational outputs are
// checked 3 units after the edge, registered outputs 1 unit after the edge.
module tb_pipeline_exe_mc;
  import exe_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid_d_i;
  logic [4:0]  alu_op_d_i;
  logic [31:0] rs1_d_i, rs2_d_i, extended_imm_d_i, pc_plus4_d_i, branch_target_d_i;
  logic        taken_d_i;
  logic [31:0] prediction_pc_d_i;
  logic        reg_write_en_d_i;
  logic [4:0]  rd_idx_d_i;
  logic [3:0]  dmem_type_d_i, result_src_d_i;
  logic        flush_e_i, st_e_i;
  logic        stall_e_o, redirection_e_o;
  logic [31:0] redirection_pc_e_o;
  logic        valid_e_o;
  logic [31:0] alu_result_e_o, extended_imm_e_o, pc_plus4_e_o;
  logic        reg_write_en_e_o;
  logic [4:0]  rd_idx_e_o;
  logic [3:0]  dmem_type_e_o, result_src_e_o;
  logic [31:0] bypass_e_o;
  logic        bypass_valid_e_o;

  int checks = 0;
  int errors = 0;
  int n;

  pipeline_exe_mc #(.XLEN(32), .MUL_LAT(3), .OP_W(5)) dut (
    .clk(clk), .resetn(resetn), .valid_d_i(valid_d_i), .alu_op_d_i(alu_op_d_i),
    .rs1_d_i(rs1_d_i), .rs2_d_i(rs2_d_i), .extended_imm_d_i(extended_imm_d_i),
    .pc_plus4_d_i(pc_plus4_d_i), .branch_target_d_i(branch_target_d_i),
    .taken_d_i(taken_d_i), .prediction_pc_d_i(prediction_pc_d_i),
    .reg_write_en_d_i(reg_write_en_d_i), .rd_idx_d_i(rd_idx_d_i),
    .dmem_type_d_i(dmem_type_d_i), .result_src_d_i(result_src_d_i),
    .flush_e_i(flush_e_i), .st_e_i(st_e_i), .stall_e_o(stall_e_o),
    .redirection_e_o(redirection_e_o), .redirection_pc_e_o(redirection_pc_e_o),
    .valid_e_o(valid_e_o), .alu_result_e_o(alu_result_e_o),
    .extended_imm_e_o(extended_imm_e_o), .pc_plus4_e_o(pc_plus4_e_o),
    .reg_write_en_e_o(reg_write_en_e_o), .rd_idx_e_o(rd_idx_e_o),
    .dmem_type_e_o(dmem_type_e_o), .result_src_e_o(result_src_e_o),
    .bypass_e_o(bypass_e_o), .bypass_valid_e_o(bypass_valid_e_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input op_e op, input logic [31:0] a, input logic [31:0] b);
    valid_d_i  = 1'b1;
    alu_op_d_i = op;
    rs1_d_i    = a;
    rs2_d_i    = b;
  endtask

  // Single-cycle op: no stall, result in EXE/MEM after one edge
  task automatic run_sc(input op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    drive(op, a, b);
    #2;
    chk({tag, "_stall"}, {63'd0, stall_e_o}, 64'd0);
    chk({tag, "_bypass"}, {32'd0, bypass_e_o}, {32'd0, exp});
    tick();
    chk({tag, "_valid"}, {63'd0, valid_e_o}, 64'd1);
    chk({tag, "_result"}, {32'd0, alu_result_e_o}, {32'd0, exp});
    valid_d_i = 1'b0;
  endtask

  // Branch/jalr: redirect seen during the retire cycle, gone the next
  task automatic run_br(input op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic tk, input logic [31:0] pred,
                        input logic exp_redir, input logic [31:0] exp_pc, input string tag);
    drive(op, a, b);
    taken_d_i         = tk;
    prediction_pc_d_i = pred;
    #2;
    chk({tag, "_redir"}, {63'd0, redirection_e_o}, {63'd0, exp_redir});
    if (exp_redir) chk({tag, "_pc"}, {32'd0, redirection_pc_e_o}, {32'd0, exp_pc});
    tick();
    chk({tag, "_valid"}, {63'd0, valid_e_o}, 64'd1);
    valid_d_i = 1'b0;
    taken_d_i = 1'b0;
    #2;
    chk({tag, "_pulse_end"}, {63'd0, redirection_e_o}, 64'd0);
    tick();
  endtask

  // Multi-cycle op: count stalled cycles, then retire from DONE
  task automatic run_mc(input op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_stall, input string tag);
    drive(op, a, b);
    #2;
    n = 0;
    while (stall_e_o && n < 100) begin
      n = n + 1;
      tick();
      #2;
    end
    chk({tag, "_stall_cycles"}, 64'(n), 64'(exp_stall));
    chk({tag, "_bypass_valid"}, {63'd0, bypass_valid_e_o}, 64'd1);
    chk({tag, "_bypass"}, {32'd0, bypass_e_o}, {32'd0, exp});
    tick();
    chk({tag, "_valid"}, {63'd0, valid_e_o}, 64'd1);
    chk({tag, "_result"}, {32'd0, alu_result_e_o}, {32'd0, exp});
    valid_d_i = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;  valid_d_i = 1'b0;  alu_op_d_i = 5'd0;
    rs1_d_i = 32'd0;  rs2_d_i = 32'd0;  extended_imm_d_i = 32'h0000_0010;
    pc_plus4_d_i = 32'h8000_0004;  branch_target_d_i = 32'h8000_0040;
    taken_d_i = 1'b0;  prediction_pc_d_i = 32'd0;
    reg_write_en_d_i = 1'b1;  rd_idx_d_i = 5'd3;  dmem_type_d_i = 4'd2;  result_src_d_i = 4'd1;
    flush_e_i = 1'b0;  st_e_i = 1'b0;

    // reset state
    repeat (3) tick();
    #2;
    chk("rst_valid", {63'd0, valid_e_o}, 64'd0);
    chk("rst_result", {32'd0, alu_result_e_o}, 64'd0);
    chk("rst_rwe", {63'd0, reg_write_en_e_o}, 64'd0);
    chk("rst_stall", {63'd0, stall_e_o}, 64'd0);
    chk("rst_redir", {63'd0, redirection_e_o}, 64'd0);
    resetn = 1'b1;
    tick();

    // single-cycle ALU
    run_sc(OP_ADD, 32'd5, 32'd7, 32'd12, "add");
    chk("add_rd", {59'd0, rd_idx_e_o}, 64'd3);
    chk("add_rwe", {63'd0, reg_write_en_e_o}, 64'd1);
    tick();
    chk("bubble_valid", {63'd0, valid_e_o}, 64'd0);
    run_sc(OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, "sub_wrap");
    run_sc(OP_SRA, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, "sra_shamt");
    run_sc(OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, "slt");
    run_sc(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, "sltu");

    // branches and jalr
    pc_plus4_d_i = 32'h8000_0004;  branch_target_d_i = 32'h8000_0040;
    run_br(OP_BEQ, 32'd3, 32'd3, 1'b0, 32'd0, 1'b1, 32'h8000_0040, "beq_nt_taken");
    pc_plus4_d_i = 32'h8000_0104;
    run_br(OP_BNE, 32'd3, 32'd3, 1'b1, 32'd0, 1'b1, 32'h8000_0104, "bne_t_not");
    run_br(OP_BLT, 32'hFFFF_FFFE, 32'd1, 1'b1, 32'd0, 1'b0, 32'd0, "blt_correct");
    extended_imm_d_i = 32'h0000_0010;
    run_br(OP_JALR, 32'h0000_1001, 32'd0, 1'b1, 32'h0000_1010, 1'b0, 32'd0, "jalr_hit");
    chk("jalr_link", {32'd0, alu_result_e_o}, {32'd0, 32'h8000_0104});
    run_br(OP_JALR, 32'h0000_1001, 32'd0, 1'b1, 32'h0000_1014, 1'b1, 32'h0000_1010, "jalr_miss");

    // multiply / divide
    run_mc(OP_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 3, "mul");
    run_mc(OP_MULHU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 3, "mulhu");
    run_mc(OP_MULH, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 3, "mulh");
    run_mc(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_neg");
    run_mc(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_neg");
    run_mc(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, "divu");
    run_mc(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_zero");
    run_mc(OP_REMU, 32'h8000_0000, 32'd0, 32'h8000_0000, 1, "remu_zero");
    run_mc(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");

    // flush in the middle of a divide
    drive(OP_DIV, 32'd100, 32'd7);
    repeat (10) tick();
    #2;
    chk("flush_mid_stall", {63'd0, stall_e_o}, 64'd1);
    flush_e_i = 1'b1;
    valid_d_i = 1'b0;
    tick();
    flush_e_i = 1'b0;
    #2;
    chk("flush_idle_stall", {63'd0, stall_e_o}, 64'd0);
    chk("flush_valid", {63'd0, valid_e_o}, 64'd0);
    tick();
    run_sc(OP_ADD, 32'd20, 32'd22, 32'd42, "add_after_flush");

    // flush kills a mispredicted branch: no redirect, nothing retires
    drive(OP_BEQ, 32'd3, 32'd3);
    taken_d_i = 1'b0;
    flush_e_i = 1'b1;
    #2;
    chk("flush_redir", {63'd0, redirection_e_o}, 64'd0);
    tick();
    flush_e_i = 1'b0;
    valid_d_i = 1'b0;
    chk("flush_kill_valid", {63'd0, valid_e_o}, 64'd0);
    chk("flush_kill_rwe", {63'd0, reg_write_en_e_o}, 64'd0);
    chk("flush_kill_dmem", {60'd0, dmem_type_e_o}, 64'd0);
    chk("flush_hold_result", {32'd0, alu_result_e_o}, 64'd42);

    // downstream stall while the multiplier sits in DONE
    drive(OP_MUL, 32'd5, 32'd9);
    #2;
    n = 0;
    while (stall_e_o && n < 100) begin
      n = n + 1;
      tick();
      #2;
    end
    chk("st_mul_stall_cycles", 64'(n), 64'd3);
    st_e_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #2;
      chk("st_hold_valid", {63'd0, valid_e_o}, 64'd0);
      chk("st_hold_result", {32'd0, alu_result_e_o}, 64'd42);
      chk("st_done_persist", {63'd0, bypass_valid_e_o}, 64'd1);
      chk("st_no_stall", {63'd0, stall_e_o}, 64'd0);
    end
    st_e_i = 1'b0;
    tick();
    valid_d_i = 1'b0;
    chk("st_release_valid", {63'd0, valid_e_o}, 64'd1);
    chk("st_release_result", {32'd0, alu_result_e_o}, 64'd45);
    #2;
    chk("st_release_idle", {63'd0, bypass_valid_e_o}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
